// File: rtl/core_cache_bus_arbiter_if.sv
// Bundle of core-side and cache-side handshake signals for the multi-channel
// core/cache bus arbiter; the arbiter takes the slave view, the environment the master view.
interface core_cache_bus_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 512,
  parameter int WORDSIZE   = 64,
  parameter int TAG_WIDTH  = 13
);
  localparam int CH_BITS = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*WORDSIZE-1:0]   core_req;
  logic [NUM_CH*TAG_WIDTH-1:0]  core_reqtag;
  logic [NUM_CH-1:0]            core_reqcyc;
  logic [NUM_CH-1:0]            core_reqack;
  logic [NUM_CH*DATA_WIDTH-1:0] core_resp;
  logic [NUM_CH*TAG_WIDTH-1:0]  core_resptag;
  logic [NUM_CH-1:0]            core_respcyc;
  logic [NUM_CH-1:0]            core_respack;

  logic [WORDSIZE-1:0]          cache_req;
  logic [TAG_WIDTH+CH_BITS-1:0] cache_reqtag;
  logic                         cache_reqcyc;
  logic                         cache_reqack;
  logic [DATA_WIDTH-1:0]        cache_resp;
  logic [TAG_WIDTH+CH_BITS-1:0] cache_resptag;
  logic                         cache_respcyc;
  logic                         cache_respack;

  logic                         tag_err;

  modport slave (
    input  core_req, core_reqtag, core_reqcyc, core_respack,
    output core_reqack, core_resp, core_resptag, core_respcyc,
    output cache_req, cache_reqtag, cache_reqcyc, cache_respack, tag_err,
    input  cache_reqack, cache_resp, cache_resptag, cache_respcyc
  );

  modport master (
    output core_req, core_reqtag, core_reqcyc, core_respack,
    input  core_reqack, core_resp, core_resptag, core_respcyc,
    input  cache_req, cache_reqtag, cache_reqcyc, cache_respack, tag_err,
    output cache_reqack, cache_resp, cache_resptag, cache_respcyc
  );
endinterface

// File: rtl/core_cache_bus_arbiter.sv
// Round-robin arbiter sharing one cache port among NUM_CH core channels, with
// channel-tagged requests, per-channel response holding registers and in-flight limits.
module core_cache_bus_arbiter #(
  parameter int NUM_CH          = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int WORDSIZE        = 64,
  parameter int TAG_WIDTH       = 13,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  core_cache_bus_arbiter_if.slave bus
);
  localparam int CH_BITS    = (NUM_CH > 2) ? $clog2(NUM_CH) : 1;
  localparam int CTAG_WIDTH = TAG_WIDTH + CH_BITS;
  localparam int OUT_BITS   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_BITS-1:0] OUT_LIMIT = OUT_BITS'(MAX_OUTSTANDING);
  localparam logic [CH_BITS-1:0]  LAST_CH   = CH_BITS'(NUM_CH - 1);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                  state_reg, state_next;
  logic [CH_BITS-1:0]      rr_ptr_reg;
  logic [OUT_BITS-1:0]     outstanding_reg [NUM_CH];
  logic [WORDSIZE-1:0]     cache_req_reg;
  logic [CTAG_WIDTH-1:0]   cache_reqtag_reg;

  logic [NUM_CH-1:0]       hold_valid_reg;
  logic [DATA_WIDTH-1:0]   hold_data_reg [NUM_CH];
  logic [TAG_WIDTH-1:0]    hold_tag_reg [NUM_CH];
  logic                    tag_err_reg;

  logic [WORDSIZE-1:0]     ch_addr [NUM_CH];
  logic [TAG_WIDTH-1:0]    ch_tag [NUM_CH];
  logic [NUM_CH-1:0]       eligible;
  logic [NUM_CH-1:0]       grant_onehot;
  logic [NUM_CH-1:0]       ch_inc;
  logic                    grant_valid;
  logic                    grant_fire;
  logic [CH_BITS-1:0]      grant_idx;

  logic [CH_BITS-1:0]      resp_ch;
  logic [NUM_CH-1:0]       resp_hit;
  logic [NUM_CH-1:0]       resp_load;
  logic [NUM_CH-1:0]       core_xfer;
  logic                    resp_ch_valid;
  logic                    resp_blocked;
  logic                    resp_xfer;

  // Per-channel wiring: payload slices, eligibility, response routing, outputs.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_addr[gi]   = bus.core_req[gi*WORDSIZE +: WORDSIZE];
    assign ch_tag[gi]    = bus.core_reqtag[gi*TAG_WIDTH +: TAG_WIDTH];
    assign eligible[gi]  = bus.core_reqcyc[gi] && (outstanding_reg[gi] < OUT_LIMIT);
    assign ch_inc[gi]    = grant_fire && (grant_idx == CH_BITS'(gi));
    assign resp_hit[gi]  = (resp_ch == CH_BITS'(gi));
    assign resp_load[gi] = resp_xfer && resp_hit[gi];
    assign core_xfer[gi] = hold_valid_reg[gi] && bus.core_respack[gi];
    assign bus.core_resp[gi*DATA_WIDTH +: DATA_WIDTH] = hold_data_reg[gi];
    assign bus.core_resptag[gi*TAG_WIDTH +: TAG_WIDTH] = hold_tag_reg[gi];
  end

  // Walk downward so the last hit is the first eligible channel at or after rr_ptr.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_reg) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (eligible[CH_BITS'(idx)]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_BITS'(idx);
      end
    end
  end

  assign grant_onehot = NUM_CH'(1) << grant_idx;
  assign grant_fire   = (state_reg == S_IDLE) && grant_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_valid) state_next = S_ISSUE;
      S_ISSUE: if (bus.cache_reqack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.core_reqack  = '0;
    bus.cache_reqcyc = 1'b0;
    case (state_reg)
      S_IDLE:  if (grant_valid && !reset) bus.core_reqack = grant_onehot;
      S_ISSUE: bus.cache_reqcyc = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_req_reg    <= '0;
      cache_reqtag_reg <= '0;
      rr_ptr_reg       <= '0;
    end else if (grant_fire) begin
      cache_req_reg    <= ch_addr[grant_idx];
      cache_reqtag_reg <= {grant_idx, ch_tag[grant_idx]};
      rr_ptr_reg       <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.cache_req    = cache_req_reg;
  assign bus.cache_reqtag = cache_reqtag_reg;

  // A response is only held off when its own channel's register is full and not draining.
  assign resp_ch       = bus.cache_resptag[TAG_WIDTH +: CH_BITS];
  assign resp_ch_valid = |resp_hit;
  assign resp_blocked  = |(resp_hit & hold_valid_reg & ~bus.core_respack);
  assign bus.cache_respack = bus.cache_respcyc && !resp_blocked && !reset;
  assign resp_xfer     = bus.cache_respcyc && bus.cache_respack;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        outstanding_reg[i] <= '0;
        hold_data_reg[i]   <= '0;
        hold_tag_reg[i]    <= '0;
      end
      hold_valid_reg <= '0;
      tag_err_reg    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Counters saturate at zero: responses to requests dropped by reset still drain.
        if (ch_inc[i] && !core_xfer[i])
          outstanding_reg[i] <= outstanding_reg[i] + 1'b1;
        else if (!ch_inc[i] && core_xfer[i] && (outstanding_reg[i] != '0))
          outstanding_reg[i] <= outstanding_reg[i] - 1'b1;
        if (resp_load[i]) begin
          hold_valid_reg[i] <= 1'b1;
          hold_data_reg[i]  <= bus.cache_resp;
          hold_tag_reg[i]   <= bus.cache_resptag[TAG_WIDTH-1:0];
        end else if (core_xfer[i]) begin
          hold_valid_reg[i] <= 1'b0;
        end
      end
      if (resp_xfer && !resp_ch_valid) tag_err_reg <= 1'b1;
    end
  end

  assign bus.core_respcyc = hold_valid_reg;
  assign bus.tag_err      = tag_err_reg;

endmodule

// File: tb/tb_core_cache_bus_arbiter.sv
// Randomized scoreboard bench for core_cache_bus_arbiter: a queue-based model
// predicts grants, cache requests and routed responses; a negedge monitor checks them.
module tb_core_cache_bus_arbiter;
  localparam int N = 4, DW = 64, AW = 32, TW = 13, MAXO = 2, CB = 2;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic reset, reset3;
  always #5 clk = ~clk;

  core_cache_bus_arbiter_if #(.NUM_CH(N), .DATA_WIDTH(DW), .WORDSIZE(AW), .TAG_WIDTH(TW)) bus ();
  core_cache_bus_arbiter_if #(.NUM_CH(N3), .DATA_WIDTH(DW), .WORDSIZE(AW), .TAG_WIDTH(TW)) bus3 ();

  core_cache_bus_arbiter #(.NUM_CH(N), .DATA_WIDTH(DW), .WORDSIZE(AW), .TAG_WIDTH(TW),
                           .MAX_OUTSTANDING(MAXO)) dut (.clk(clk), .reset(reset), .bus(bus));
  core_cache_bus_arbiter #(.NUM_CH(N3), .DATA_WIDTH(DW), .WORDSIZE(AW), .TAG_WIDTH(TW),
                           .MAX_OUTSTANDING(MAXO)) dut3 (.clk(clk), .reset(reset3), .bus(bus3));

  typedef struct packed { logic [AW-1:0] addr; logic [TW+CB-1:0] tag; } req_t;
  typedef struct packed { logic [DW-1:0] data; logic [TW-1:0] tag; } rsp_t;

  int n_checks = 0, n_fail = 0;
  bit mon_en = 0;

  // reference model state
  int m_ptr, m_cnt[N];
  bit m_busy;
  bit req_pend[N];
  logic [AW-1:0] req_addr[N];
  logic [TW-1:0] req_tag[N];
  req_t req_sb[$];
  logic [TW+CB-1:0] iss_q[$], pool[$];
  rsp_t resp_q[N][$];
  bit rsp_act;
  logic [TW+CB-1:0] rsp_tag;
  logic [DW-1:0] rsp_data;
  bit cack_drv;
  bit [N-1:0] rack_drv;

  // predictions for the next rising edge
  int p_g;
  logic [N-1:0] p_ack, p_core_xfer;
  bit p_cache_xfer, p_cresp_ack;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.core_reqcyc[i] = req_pend[i];
      bus.core_req[i*AW +: AW] = req_addr[i];
      bus.core_reqtag[i*TW +: TW] = req_tag[i];
      bus.core_respack[i] = rack_drv[i];
    end
    bus.cache_reqack  = cack_drv;
    bus.cache_respcyc = rsp_act;
    bus.cache_resptag = rsp_tag;
    bus.cache_resp    = rsp_data;
  endtask

  task automatic predict();
    int ch;
    p_g = -1;
    if (!m_busy)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (p_g < 0 && req_pend[i] && m_cnt[i] < MAXO) p_g = i;
      end
    p_ack = (p_g >= 0) ? (N'(1) << p_g) : '0;
    p_cache_xfer = m_busy && cack_drv;
    for (int i = 0; i < N; i++) p_core_xfer[i] = (resp_q[i].size() > 0) && rack_drv[i];
    ch = int'(rsp_tag[TW +: CB]);
    p_cresp_ack = rsp_act && (resp_q[ch].size() == 0 || rack_drv[ch]);
  endtask

  task automatic model_clear();
    m_ptr = 0; m_busy = 0; rsp_act = 0; cack_drv = 0;
    req_sb.delete(); iss_q.delete(); pool.delete();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      resp_q[i].delete();
    end
  endtask

  // One cycle: commit predicted transfers, draw new stimulus, predict next edge.
  task automatic step(input int req_p, input int cack_p, input int rsp_p, input int rack_p, input bit ack3);
    int ch, idx;
    @(posedge clk); #1;
    if (p_g >= 0) begin
      req_sb.push_back('{addr: req_addr[p_g], tag: {CB'(p_g), req_tag[p_g]}});
      iss_q.push_back({CB'(p_g), req_tag[p_g]});
      req_pend[p_g] = 0;
      m_cnt[p_g]++;
      m_ptr = (p_g + 1) % N;
      m_busy = 1;
    end
    if (p_cache_xfer) begin
      pool.push_back(iss_q.pop_front());
      m_busy = 0;
    end
    for (int i = 0; i < N; i++)
      if (p_core_xfer[i] && m_cnt[i] > 0) m_cnt[i]--;
    if (p_cresp_ack) begin
      ch = int'(rsp_tag[TW +: CB]);
      resp_q[ch].push_back('{data: rsp_data, tag: rsp_tag[TW-1:0]});
      rsp_act = 0;
    end
    for (int i = 0; i < N; i++)
      if (!req_pend[i] && $urandom_range(99) < req_p) begin
        req_pend[i] = 1;
        req_addr[i] = $urandom;
        req_tag[i]  = TW'($urandom);
      end
    cack_drv = ($urandom_range(99) < cack_p);
    if (!rsp_act && pool.size() > 0 && $urandom_range(99) < rsp_p) begin
      idx = $urandom_range(pool.size() - 1);
      rsp_tag = pool[idx];
      pool.delete(idx);
      rsp_data = {$urandom, $urandom};
      rsp_act = 1;
    end
    for (int i = 0; i < N; i++) rack_drv[i] = ($urandom_range(99) < rack_p);
    if (ack3) rack_drv[3] = 1;
    drive();
    predict();
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(posedge clk); #1;
    reset = 1;
    rsp_act = 0; cack_drv = 0;
    drive();
    @(negedge clk);
    chk("rst_reqack_gated", 128'(bus.core_reqack), 128'(0));
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    drive();
    predict();
    @(negedge clk);
    chk("rst_cache_reqcyc", 128'(bus.cache_reqcyc), 128'(0));
    chk("rst_core_respcyc", 128'(bus.core_respcyc), 128'(0));
    chk("rst_tag_err", 128'(bus.tag_err), 128'(0));
    chk("rst_reqack", 128'(bus.core_reqack), 128'(p_ack));
    mon_en = 1;
  endtask

  always @(negedge clk) begin : monitor
    req_t e;
    rsp_t r;
    if (mon_en) begin
      chk("reqack", 128'(bus.core_reqack), 128'(p_ack));
      chk("cache_reqcyc", 128'(bus.cache_reqcyc), 128'(m_busy));
      chk("cache_respack", 128'(bus.cache_respack), 128'(p_cresp_ack));
      chk("tag_err_quiet", 128'(bus.tag_err), 128'(0));
      if (bus.cache_reqcyc && bus.cache_reqack) begin
        if (req_sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL cache_req_extra actual=%0h required=none", bus.cache_reqtag);
        end else begin
          e = req_sb.pop_front();
          chk("cache_req", 128'(bus.cache_req), 128'(e.addr));
          chk("cache_reqtag", 128'(bus.cache_reqtag), 128'(e.tag));
        end
      end
      for (int i = 0; i < N; i++) begin
        chk($sformatf("core_respcyc%0d", i), 128'(bus.core_respcyc[i]), 128'(resp_q[i].size() > 0));
        if (bus.core_respcyc[i] && resp_q[i].size() > 0) begin
          r = resp_q[i][0];
          chk($sformatf("core_resp%0d", i), 128'(bus.core_resp[i*DW +: DW]), 128'(r.data));
          chk($sformatf("core_resptag%0d", i), 128'(bus.core_resptag[i*TW +: TW]), 128'(r.tag));
          if (bus.core_respack[i]) void'(resp_q[i].pop_front());
        end
      end
    end
  end

  task automatic tag_err_test();
    @(posedge clk); #1 reset3 = 0;
    @(negedge clk);
    chk("t3_rst_err", 128'(bus3.tag_err), 128'(0));
    @(posedge clk); #1;
    bus3.cache_respcyc = 1;
    bus3.cache_resptag = {2'd3, 13'h055};
    bus3.cache_resp    = 64'h1111_2222_3333_4444;
    @(negedge clk);
    chk("t3_oor_ack", 128'(bus3.cache_respack), 128'(1));
    @(posedge clk); #1 bus3.cache_respcyc = 0;
    @(negedge clk);
    chk("t3_oor_respcyc", 128'(bus3.core_respcyc), 128'(0));
    chk("t3_tag_err_set", 128'(bus3.tag_err), 128'(1));
    @(posedge clk); #1;
    bus3.cache_respcyc = 1;
    bus3.cache_resptag = {2'd1, 13'h0AB};
    bus3.cache_resp    = 64'h0000_0000_0000_DEAD;
    @(negedge clk);
    chk("t3_valid_ack", 128'(bus3.cache_respack), 128'(1));
    @(posedge clk); #1 bus3.cache_respcyc = 0;
    @(negedge clk);
    chk("t3_respcyc", 128'(bus3.core_respcyc), 128'(3'b010));
    chk("t3_resptag", 128'(bus3.core_resptag[TW +: TW]), 128'(13'h0AB));
    chk("t3_resp", 128'(bus3.core_resp[DW +: DW]), 128'(64'hDEAD));
    chk("t3_tag_err_sticky", 128'(bus3.tag_err), 128'(1));
    @(posedge clk); #1 reset3 = 1;
    @(posedge clk); #1 reset3 = 0;
    @(negedge clk);
    chk("t3_tag_err_clr", 128'(bus3.tag_err), 128'(0));
    chk("t3_respcyc_clr", 128'(bus3.core_respcyc), 128'(0));
  endtask

  initial begin
    reset = 1; reset3 = 1;
    for (int i = 0; i < N; i++) begin
      req_pend[i] = 0; req_addr[i] = '0; req_tag[i] = '0;
    end
    rack_drv = '0; rsp_tag = '0; rsp_data = '0;
    model_clear();
    drive();
    bus3.core_req = '0; bus3.core_reqtag = '0; bus3.core_reqcyc = '0; bus3.core_respack = '0;
    bus3.cache_reqack = 0; bus3.cache_resp = '0; bus3.cache_resptag = '0; bus3.cache_respcyc = 0;
    predict();
    repeat (2) @(posedge clk);
    do_reset();
    // all channels requesting, no responses: rotation then saturation at the limit
    repeat (30) step(100, 100, 0, 50, 0);
    // mixed random traffic with out-of-order responses and back-pressure
    repeat (400) step(60, 70, 60, 60, 0);
    // channel 3 always draining, cache pushing responses as fast as it can
    repeat (200) step(80, 100, 100, 30, 1);
    // stall the cache port so the arbiter sits in ISSUE, then reset
    repeat (6) step(100, 0, 50, 50, 0);
    do_reset();
    repeat (300) step(50, 50, 50, 50, 0);
    mon_en = 0;
    tag_err_test();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/core_cache_bus_arbiter.md
Name: core_cache_bus_arbiter

Overview:
- Multi-channel successor to the single core/icache bus.
- Lets NUM_CH core-side requesters (fetch, data, prefetch, page walker) share one cache-side port using the same req/reqtag/reqcyc/reqack and resp/resptag/respcyc/respack handshake.
- Requests are arbitrated round-robin and tagged with the channel index. Responses are routed back by tag into per-channel holding registers.
- Outstanding requests are limited per channel.

Parameters:
NUM_CH, 4, number of core-side channels (2..8)
DATA_WIDTH, 512, response (cache line) width
WORDSIZE, 64, request address width
TAG_WIDTH, 13, core-side tag width
MAX_OUTSTANDING, 2, per-channel in-flight limit (1..7)
CH_BITS (localparam), max(1,clog2(NUM_CH)), channel field width; cache tag width is TAG_WIDTH+CH_BITS

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_req  in  NUM_CH*WORDSIZE  per-channel request address, channel i at slice i
core_reqtag  in  NUM_CH*TAG_WIDTH  per-channel request tag
core_reqcyc  in  NUM_CH  request valid
core_reqack  out  NUM_CH  request accepted
core_resp  out  NUM_CH*DATA_WIDTH  per-channel response data
core_resptag  out  NUM_CH*TAG_WIDTH  per-channel response tag
core_respcyc  out  NUM_CH  response valid
core_respack  in  NUM_CH  response consumed
cache_req  out  WORDSIZE  request to cache
cache_reqtag  out  TAG_WIDTH+CH_BITS  {channel, core tag}
cache_reqcyc  out  1  request valid
cache_reqack  in  1  cache accepted request
cache_resp  in  DATA_WIDTH  response data
cache_resptag  in  TAG_WIDTH+CH_BITS  {channel, core tag}
cache_respcyc  in  1  response valid
cache_respack  out  1  response accepted
tag_err  out  1  sticky: response carried a channel index >= NUM_CH

Behaviour:
- Transfer rule: a transfer occurs on any rising clk where cyc and ack are both high. A source holds cyc and its payload stable until that transfer.
- Reset: applies to all state. Synchronous reset forces:
  - all core_reqack, core_respcyc, cache_reqcyc, cache_respack and tag_err to 0;
  - data/tag outputs to 0;
  - round-robin pointer to 0;
  - outstanding counters to 0;
  - request FSM to IDLE.
  In-flight transactions are discarded; responses arriving afterwards are handled under normal rules.
- Request FSM states:
  - IDLE: a channel is eligible when core_reqcyc[i]=1 and outstanding[i] < MAX_OUTSTANDING. Choose the first eligible channel at or after rr_ptr, wrapping modulo NUM_CH. On grant:
    - core_reqack[i]=1 combinationally in that cycle (single-cycle pulse);
    - req and {i,tag} are registered into cache_req/cache_reqtag;
    - rr_ptr <= (i+1) mod NUM_CH;
    - outstanding[i] increments;
    - next state ISSUE.
    With no eligible channel, stay in IDLE.
  - ISSUE: cache_reqcyc=1 with registered payload. On cache_reqack, go to IDLE. No new grant happens in the same cycle, so throughput is at most one request every 2 cycles.
- Request latency: the earliest cache_reqcyc is 1 cycle after core_reqcyc is sampled with a grant.
- Response path: per channel, one holding register {valid, data, tag}.
  - cache_respack = cache_respcyc && (ch >= NUM_CH || !hold_valid[ch] || core_respack[ch]), where ch = cache_resptag upper CH_BITS. This allows same-cycle drain and refill.
  - On cache transfer to a valid ch: the holding register loads next cycle, core_respcyc[ch]=1 and core_resptag = lower TAG_WIDTH bits.
  - Response latency: 1 cycle from cache_respcyc to core_respcyc when the holding register is free.
  - core_respcyc[ch] stays high until core_respack[ch]. On consume with no refill, valid clears.
- Outstanding counters: outstanding[i] decrements on a core-side response transfer. A simultaneous increment and decrement leaves it unchanged. It never wraps.
- Out-of-range channel (ch >= NUM_CH): the response is acked and dropped, and tag_err is set until reset.
- Channel isolation: responses for different channels never block each other, except that the cache port serves one response per cycle.

Test Plan:
1. Reset mid-ISSUE (cache_reqack held 0) -> next cycle cache_reqcyc=0, all counters 0, tag_err=0, core_respcyc=0.
2. All 4 channels hold reqcyc from reset, cache_reqack=1 always -> grant order 0,1,2,3,0; each cache_reqtag upper bits match the channel; one grant every 2 cycles.
3. Channel 1 issues 2 requests and receives no responses, MAX_OUTSTANDING=2 -> third request not acked while channels 0/2 are still granted. After one response to ch1 is consumed, ch1 is granted again.
4. Response with resptag {2'd2,13'h0AB}, data 0x…DEAD, core_respack[2]=0 -> core_respcyc[2]=1 with tag 0x0AB held. A second response to ch2 is not acked until core_respack[2]; a response to ch0 in between is accepted.
5. Back-to-back responses to ch3 with core_respack[3] tied 1 -> cache_respack=1 every cycle; data delivered in order, 1-cycle latency each.
6. NUM_CH=3, response with channel field 3 -> cache_respack=1, no core_respcyc, tag_err=1 until reset.
